alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand/op set present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  3  operation select.
REQ-009 SHALL have port acc_clr  input  1  synchronous accumulator clear.
REQ-010 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port y  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  registered {N,Z,C,V}.

Function
REQ-014 SHALL decode op: 000 ~A; 001 A+B; 010 A-B; 011 A+A; 100 A&B; 101 A|B; 110 A^B; 111 ACC = acc+A.
REQ-015 SHALL accept an operand set when in_valid && in_ready (transfer).
REQ-016 SHALL drive in_ready = !out_valid || out_ready (one-deep output register, full throughput).
REQ-017 SHALL load y/flags and set out_valid on the clock edge of a transfer: latency exactly 1 cycle.
REQ-018 SHALL clear out_valid when out_ready && out_valid and no transfer occurs in the same cycle.
REQ-019 SHALL hold y, flags, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute arithmetic in WIDTH+1 bits; y = low WIDTH bits (wrap-around).
REQ-021 SHALL set C = carry-out for ADD/DBL/ACC, C = borrow (A<B unsigned) for SUB, C=0 for NOT/AND/OR/XOR.
REQ-022 SHALL set V = two's-complement signed overflow for ADD/SUB/DBL/ACC, V=0 for logic ops.
REQ-023 SHALL set Z = (y==0) and N = y[WIDTH-1], from the final (post-saturation) result.
REQ-024 SHALL update internal acc only on a transfer with op=111; y for ACC = new acc value.
REQ-025 SHALL clear acc to 0 on acc_clr=1 regardless of in_valid.
REQ-026 SHALL, when acc_clr coincides with an ACC transfer, compute acc = 0 + A (clear first) and report that as y.
REQ-027 SHALL not allow acc_clr to affect out_valid, y or flags of non-ACC operations.

Reset
REQ-028 SHALL on rst_n=0 immediately force out_valid=0, y=0, flags=0, acc=0; in_ready=1 follows.
REQ-029 SHALL discard any held, unconsumed result when reset asserts mid-operation.
REQ-030 SHALL accept the first transfer on the first rising clk after rst_n deasserts.

Configuration
REQ-031 SHALL, with ALU_PIPE_SAT_EN defined, clamp ADD/SUB/DBL/ACC results on V=1 to signed max (0111..) or min (1000..) per operand sign; acc stores clamped value; V still reports overflow.
REQ-032 SHALL, without ALU_PIPE_SAT_EN, wrap all arithmetic results (REQ-020); no other behaviour differs.

Structure
REQ-033 SHALL place op encodings (localparam/enum) and flag bit indices in shared package alu_pkg.
REQ-034 SHALL implement the combinational datapath (ops, flags, saturation) as sub-module alu_core; alu_pipe holds handshake, output register and acc.

Verification (WIDTH=8)
REQ-035 SHALL check reset: rst_n low mid-stall with out_valid=1 -> out_valid=0, y=0, flags=0 immediately, no clk needed.
REQ-036 SHALL check arithmetic: ADD 0x7F+0x01 -> y=0x80, N=1 Z=0 C=0 V=1 (SAT_EN: y=0x7F); SUB 0x00-0x01 -> y=0xFF, C=1 V=0.
REQ-037 SHALL check ops: NOT 0x0F -> 0xF0; DBL 0x81 -> y=0x02, C=1, V=1; XOR 0xAA^0xAA -> y=0, Z=1.
REQ-038 SHALL check backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, y held; next transfer accepted in the cycle out_ready rises.
REQ-039 SHALL check accumulator: ACC 5, ACC 7 -> y=5 then 12; acc_clr with ACC 3 same cycle -> y=3.
REQ-040 SHALL check streaming: in_valid and out_ready held 1 for 16 random ops -> one result per cycle, 1-cycle latency, matches reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_DBL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_ACC = 3'b111
    } op_e;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operation decode, flag generation and optional
// signed saturation (enabled by defining ALU_PIPE_SAT_EN).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_lhs;
    logic [WIDTH-1:0] w_rhs;
    logic             w_sub;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_lhs   = a;
        w_rhs   = b;
        w_sub   = 1'b0;
        w_arith = 1'b0;
        case (op)
            OP_ADD: w_arith = 1'b1;
            OP_SUB: begin w_arith = 1'b1; w_sub = 1'b1; end
            OP_DBL: begin w_arith = 1'b1; w_rhs = a; end
            OP_ACC: begin w_arith = 1'b1; w_lhs = acc; w_rhs = a; end
            default: ;
        endcase

        // One extra bit holds carry-out for add and borrow for subtract.
        w_sum = w_sub ? ({1'b0, w_lhs} - {1'b0, w_rhs})
                      : ({1'b0, w_lhs} + {1'b0, w_rhs});

        w_c = 1'b0;
        w_v = 1'b0;
        if (w_arith) begin
            w_c = w_sum[WIDTH];
            if (w_sub)
                w_v = (w_lhs[WIDTH-1] != w_rhs[WIDTH-1]) && (w_sum[WIDTH-1] != w_lhs[WIDTH-1]);
            else
                w_v = (w_lhs[WIDTH-1] == w_rhs[WIDTH-1]) && (w_sum[WIDTH-1] != w_lhs[WIDTH-1]);
        end

        case (op)
            OP_NOT:  w_res = ~a;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            default: w_res = w_sum[WIDTH-1:0];
        endcase

`ifdef ALU_PIPE_SAT_EN
        // Overflow always pushes the result away from the left operand's sign.
        if (w_v)
            w_res = w_lhs[WIDTH-1] ? SMIN : SMAX;
`endif

        y              = w_res;
        flags          = 4'b0000;
        flags[FLAG_N]  = w_res[WIDTH-1];
        flags[FLAG_Z]  = (w_res == '0);
        flags[FLAG_C]  = w_c;
        flags[FLAG_V]  = w_v;
    end

`ifndef ALU_PIPE_SAT_EN
    logic w_unused_sat;
    assign w_unused_sat = ^{SMAX, SMIN};
`endif

endmodule

// File: rtl/alu_pipe.sv
// One-stage pipelined ALU with valid/ready handshake and accumulator.
// Optional signed saturation of arithmetic results via ALU_PIPE_SAT_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;

    logic             w_xfer;
    logic             w_is_acc;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_y;
    logic [3:0]       w_flags;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_xfer    = in_valid && in_ready;
    assign w_is_acc  = (op == OP_ACC);
    // A clear in the same cycle as an ACC transfer is applied before the add.
    assign w_acc_eff = acc_clr ? '0 : r_acc;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .acc   (w_acc_eff),
        .op    (op_e'(op)),
        .y     (w_y),
        .flags (w_flags)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_xfer) begin
                r_y         <= w_y;
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer && w_is_acc)
                r_acc <= w_y;
            else if (acc_clr)
                r_acc <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): stimulus pushes hand-computed results,
// a negedge monitor pops and compares each consumed output.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [3:0] flags;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y", {24'd0, y}, {24'd0, e.y});
                check("flags", {28'd0, flags}, {28'd0, e.f});
            end
        end
    end

    // Drive one operand set, wait for the transfer edge, record expected result.
    task automatic send(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic clr, input logic [7:0] ey, input logic [3:0] ef,
                        output int cyc);
        logic rdy;
        exp_t e;
        in_valid = 1'b1;
        op       = o;
        a        = ia;
        b        = ib;
        acc_clr  = clr;
        cyc      = 0;
        rdy      = 1'b0;
        while (!rdy && cyc < 20) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            cyc++;
        end
        if (rdy) begin
            e.y = ey;
            e.f = ef;
            sb.push_back(e);
        end else begin
            check("send_timeout", 32'd1, 32'd0);
        end
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_sb_empty", sb.size(), 32'd0);
    endtask

    typedef struct {
        logic [2:0] o;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] y;
        logic [3:0] f;
    } vec_t;

    vec_t stream[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        stream[0]  = '{OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 4'h0};
        stream[1]  = '{OP_SUB, 8'h34, 8'h12, 1'b0, 8'h22, 4'h0};
        stream[2]  = '{OP_AND, 8'hC3, 8'h5A, 1'b0, 8'h42, 4'h0};
        stream[3]  = '{OP_OR,  8'h01, 8'h80, 1'b0, 8'h81, 4'h8};
        stream[4]  = '{OP_XOR, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'h8};
        stream[5]  = '{OP_NOT, 8'h00, 8'h00, 1'b0, 8'hFF, 4'h8};
        stream[6]  = '{OP_DBL, 8'h30, 8'h00, 1'b0, 8'h60, 4'h0};
        stream[7]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'h6};
        stream[8]  = '{OP_SUB, 8'h10, 8'h20, 1'b0, 8'hF0, 4'hA};
        stream[9]  = '{OP_ACC, 8'h10, 8'h00, 1'b1, 8'h10, 4'h0};
        stream[10] = '{OP_ACC, 8'h20, 8'h00, 1'b0, 8'h30, 4'h0};
        stream[11] = '{OP_ADD, 8'hF0, 8'hF0, 1'b0, 8'hE0, 4'hA};
        stream[12] = '{OP_SUB, 8'h7F, 8'h7F, 1'b0, 8'h00, 4'h4};
        stream[13] = '{OP_DBL, 8'hFF, 8'h00, 1'b0, 8'hFE, 4'hA};
        stream[14] = '{OP_NOT, 8'hAA, 8'h00, 1'b0, 8'h55, 4'h0};
        stream[15] = '{OP_ACC, 8'hE0, 8'h00, 1'b0, 8'h10, 4'h2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arithmetic and logic corners.
`ifdef ALU_PIPE_SAT_EN
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h7F, 4'h1, cyc);
`else
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'h9, cyc);
`endif
        check("first_xfer_cycles", cyc, 32'd1);
        send(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'hA, cyc);
        send(OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'h8, cyc);
`ifdef ALU_PIPE_SAT_EN
        send(OP_DBL, 8'h81, 8'h00, 1'b0, 8'h80, 4'hB, cyc);
`else
        send(OP_DBL, 8'h81, 8'h00, 1'b0, 8'h02, 4'h3, cyc);
`endif
        send(OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'h4, cyc);

        // Accumulator, clear-with-ACC, and clear alongside a non-ACC op.
        send(OP_ACC, 8'h05, 8'h00, 1'b0, 8'h05, 4'h0, cyc);
        send(OP_ACC, 8'h07, 8'h00, 1'b0, 8'h0C, 4'h0, cyc);
        send(OP_ACC, 8'h03, 8'h00, 1'b1, 8'h03, 4'h0, cyc);
        send(OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'h0, cyc);
        send(OP_ACC, 8'h01, 8'h00, 1'b0, 8'h01, 4'h0, cyc);
        drain();

        // Backpressure: result held for 3 cycles, next set taken when out_ready rises.
        out_ready = 1'b0;
        send(OP_OR, 8'h50, 8'h0A, 1'b0, 8'h5A, 4'h0, cyc);
        in_valid = 1'b1;
        op       = OP_AND;
        a        = 8'hF0;
        b        = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_y_hold", {24'd0, y}, 32'h5A);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'h0, cyc);
        check("bp_release_cycles", cyc, 32'd1);
        drain();

        // Reset while a result is stalled: cleared without a clock edge.
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 4'h0, cyc);
        #2;
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_y", {24'd0, y}, 32'd0);
        check("async_rst_flags", {28'd0, flags}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(OP_SUB, 8'h05, 8'h03, 1'b0, 8'h02, 4'h0, cyc);
        check("post_rst_first_xfer", cyc, 32'd1);
        send(OP_ACC, 8'h04, 8'h00, 1'b0, 8'h04, 4'h0, cyc);
        drain();

        // Streaming: one transfer per cycle with in_valid/out_ready held high.
        foreach (stream[i]) begin
            send(stream[i].o, stream[i].a, stream[i].b, stream[i].clr,
                 stream[i].y, stream[i].f, cyc);
            check("stream_cycles", cyc, 32'd1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
